find_multi_points: RTL and testbench

- Scans a raster-ordered binary (thresholded) video frame and locates up to 4 separate bright blobs, e.g. motion-capture markers.
- Sits after the binarisation stage in the D8M camera/VGA pipeline. It uses the VGA timing strobes and pixel counters.
- At the end of each frame it publishes the bounding-box centre of each blob, a validity mask and a blob count. These values hold stable until the next frame ends.

---
 rtl/find_multi_points.sv | 156 +++++++++++++++
 tb/tb_find_multi_points.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/find_multi_points.sv
`default_nettype none
// ============================================================================
// Module   : find_multi_points
// Purpose  : Tracks up to four foreground blobs per binary frame; reports centres at frame end.
// Revision : 1.0
// ============================================================================
module find_multi_points #(
    parameter int GAP        = 2,
    parameter int MAX_POINTS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        BINARY_FLAG,
    input  logic [15:0] H_CNT,
    input  logic [15:0] V_CNT,
    output logic [15:0] o_POINTS_H_0,
    output logic [15:0] o_POINTS_H_1,
    output logic [15:0] o_POINTS_H_2,
    output logic [15:0] o_POINTS_H_3,
    output logic [15:0] o_POINTS_V_0,
    output logic [15:0] o_POINTS_V_1,
    output logic [15:0] o_POINTS_V_2,
    output logic [15:0] o_POINTS_V_3,
    output logic [15:0] o_POINTS_LIST,
    output logic [15:0] o_POINTS_NUM,
    output logic [15:0] test
);

    localparam logic [16:0]           c_GAP = 17'(GAP);
    localparam logic [MAX_POINTS-1:0] c_ONE = MAX_POINTS'(1);

    logic                  r_vs;
    logic [MAX_POINTS-1:0] r_valid;
    logic [15:0]           r_min_h [MAX_POINTS];
    logic [15:0]           r_max_h [MAX_POINTS];
    logic [15:0]           r_min_v [MAX_POINTS];
    logic [15:0]           r_max_v [MAX_POINTS];
    logic [15:0]           r_drop;
    logic [15:0]           r_pts_h [MAX_POINTS];
    logic [15:0]           r_pts_v [MAX_POINTS];
    logic [MAX_POINTS-1:0] r_list;
    logic [15:0]           r_num;
    logic [15:0]           r_test;

    logic                  w_vs_rise;
    logic                  w_vs_fall;
    logic                  w_pix;
    logic [MAX_POINTS-1:0] w_live;
    logic [MAX_POINTS-1:0] w_match;
    logic [MAX_POINTS-1:0] w_free;
    logic [MAX_POINTS-1:0] w_sel;
    logic                  w_hit;
    logic                  w_drop;
    logic [15:0]           w_cx [MAX_POINTS];
    logic [15:0]           w_cy [MAX_POINTS];
    logic [15:0]           w_num;

    assign w_vs_rise = VGA_VS & ~r_vs;
    assign w_vs_fall = r_vs & ~VGA_VS;
    assign w_pix     = VGA_VS & VGA_HS & BINARY_FLAG;
    // A frame-start cycle sees every slot as already cleared.
    assign w_live    = r_valid & ~{MAX_POINTS{w_vs_rise}};

    for (genvar n = 0; n < MAX_POINTS; n++) begin : g_slot
        logic [16:0] w_lo_h;
        assign w_lo_h     = ({1'b0, r_min_h[n]} >= c_GAP) ? ({1'b0, r_min_h[n]} - c_GAP) : 17'd0;
        assign w_match[n] = w_live[n]
                          & ({1'b0, H_CNT} >= w_lo_h)
                          & ({1'b0, H_CNT} <= ({1'b0, r_max_h[n]} + c_GAP))
                          & ({1'b0, V_CNT} <= ({1'b0, r_max_v[n]} + c_GAP))
                          & (V_CNT >= r_min_v[n]);
        assign w_free[n]  = ~w_live[n];
        assign w_cx[n]    = 16'(({1'b0, r_min_h[n]} + {1'b0, r_max_h[n]}) >> 1);
        assign w_cy[n]    = 16'(({1'b0, r_min_v[n]} + {1'b0, r_max_v[n]}) >> 1);
    end

    // Lowest-index slot wins: isolate the lowest set bit of the candidate mask.
    assign w_hit  = |w_match;
    assign w_sel  = w_hit ? (w_match & (~w_match + c_ONE)) : (w_free & (~w_free + c_ONE));
    assign w_drop = ~w_hit & ~|w_free;

    always_comb begin
        w_num = 16'd0;
        for (int n = 0; n < MAX_POINTS; n++) begin
            w_num = w_num + 16'(r_valid[n]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vs    <= 1'b0;
            r_valid <= '0;
            r_drop  <= 16'd0;
            r_list  <= '0;
            r_num   <= 16'd0;
            r_test  <= 16'd0;
            for (int n = 0; n < MAX_POINTS; n++) begin
                r_min_h[n] <= 16'd0;
                r_max_h[n] <= 16'd0;
                r_min_v[n] <= 16'd0;
                r_max_v[n] <= 16'd0;
                r_pts_h[n] <= 16'd0;
                r_pts_v[n] <= 16'd0;
            end
        end else begin
            r_vs <= VGA_VS;
            if (w_vs_rise) begin
                r_valid <= '0;
                r_drop  <= 16'd0;
            end
            if (w_pix) begin
                for (int n = 0; n < MAX_POINTS; n++) begin
                    if (w_sel[n]) begin
                        if (w_hit) begin
                            if (H_CNT < r_min_h[n]) r_min_h[n] <= H_CNT;
                            if (H_CNT > r_max_h[n]) r_max_h[n] <= H_CNT;
                            if (V_CNT > r_max_v[n]) r_max_v[n] <= V_CNT;
                        end else begin
                            r_min_h[n] <= H_CNT;
                            r_max_h[n] <= H_CNT;
                            r_min_v[n] <= V_CNT;
                            r_max_v[n] <= V_CNT;
                            r_valid[n] <= 1'b1;
                        end
                    end
                end
                if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
            end
            if (w_vs_fall) begin
                for (int n = 0; n < MAX_POINTS; n++) begin
                    r_pts_h[n] <= r_valid[n] ? w_cx[n] : 16'd0;
                    r_pts_v[n] <= r_valid[n] ? w_cy[n] : 16'd0;
                end
                r_list <= r_valid;
                r_num  <= w_num;
                r_test <= r_drop;
            end
        end
    end

    assign o_POINTS_H_0  = r_pts_h[0];
    assign o_POINTS_H_1  = r_pts_h[1];
    assign o_POINTS_H_2  = r_pts_h[2];
    assign o_POINTS_H_3  = r_pts_h[3];
    assign o_POINTS_V_0  = r_pts_v[0];
    assign o_POINTS_V_1  = r_pts_v[1];
    assign o_POINTS_V_2  = r_pts_v[2];
    assign o_POINTS_V_3  = r_pts_v[3];
    assign o_POINTS_LIST = {{(16-MAX_POINTS){1'b0}}, r_list};
    assign o_POINTS_NUM  = r_num;
    assign test          = r_test;

endmodule
`default_nettype wire

// File: tb/tb_find_multi_points.sv
`default_nettype none
// ============================================================================
// Module   : tb_find_multi_points
// Purpose  : Directed frame-level checks of find_multi_points blob reporting.
// Revision : 1.0
// ============================================================================
module tb_find_multi_points;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        VGA_HS = 1'b0;
    logic        VGA_VS = 1'b0;
    logic        BINARY_FLAG = 1'b0;
    logic [15:0] H_CNT = 16'd0;
    logic [15:0] V_CNT = 16'd0;
    logic [15:0] o_h [4];
    logic [15:0] o_v [4];
    logic [15:0] o_list;
    logic [15:0] o_num;
    logic [15:0] o_test;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_h [4];
    logic [15:0] exp_v [4];
    logic [15:0] exp_list;
    logic [15:0] exp_num;
    logic [15:0] exp_test;

    always #5 CLK = ~CLK;

    find_multi_points dut (
        .CLK          (CLK),
        .RST          (RST),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .BINARY_FLAG  (BINARY_FLAG),
        .H_CNT        (H_CNT),
        .V_CNT        (V_CNT),
        .o_POINTS_H_0 (o_h[0]),
        .o_POINTS_H_1 (o_h[1]),
        .o_POINTS_H_2 (o_h[2]),
        .o_POINTS_H_3 (o_h[3]),
        .o_POINTS_V_0 (o_v[0]),
        .o_POINTS_V_1 (o_v[1]),
        .o_POINTS_V_2 (o_v[2]),
        .o_POINTS_V_3 (o_v[3]),
        .o_POINTS_LIST(o_list),
        .o_POINTS_NUM (o_num),
        .test         (o_test)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic check(input string tag);
        for (int n = 0; n < 4; n++) begin
            cmp($sformatf("%s.H%0d", tag, n), o_h[n], exp_h[n]);
            cmp($sformatf("%s.V%0d", tag, n), o_v[n], exp_v[n]);
        end
        cmp({tag, ".LIST"}, o_list, exp_list);
        cmp({tag, ".NUM"},  o_num,  exp_num);
        cmp({tag, ".test"}, o_test, exp_test);
    endtask

    task automatic set_exp(input int h0, v0, h1, v1, h2, v2, h3, v3, list, num, drop);
        exp_h[0] = 16'(h0); exp_v[0] = 16'(v0);
        exp_h[1] = 16'(h1); exp_v[1] = 16'(v1);
        exp_h[2] = 16'(h2); exp_v[2] = 16'(v2);
        exp_h[3] = 16'(h3); exp_v[3] = 16'(v3);
        exp_list = 16'(list); exp_num = 16'(num); exp_test = 16'(drop);
    endtask

    function automatic logic inbox(input int x, y, x0, y0, s);
        return (x >= x0) && (x < x0 + s) && (y >= y0) && (y < y0 + s);
    endfunction

    function automatic logic fg(input int mode, x, y);
        case (mode)
            1: return inbox(x, y, 10, 20, 5);
            2: return inbox(x, y, 29, 9, 3) || inbox(x, y, 89, 9, 3) ||
                      inbox(x, y, 149, 39, 3) || inbox(x, y, 49, 79, 3);
            3: return inbox(x, y, 10, 10, 2) || inbox(x, y, 40, 10, 2) ||
                      inbox(x, y, 70, 30, 2) || inbox(x, y, 10, 60, 2) ||
                      inbox(x, y, 100, 90, 2);
            4: return ((x == 40) || (x == 42)) && (y == 5);
            5: return ((x == 40) || (x == 43)) && (y == 5);
            default: return 1'b0;
        endcase
    endfunction

    // One frame: VS high, two blanking cycles before each line, VS drop at the end.
    // hold_chk compares outputs against exp_* at each line start; rst_line pulses RST there.
    task automatic run_frame(input int mode, w, h, input bit hold_chk, input int rst_line);
        VGA_VS = 1'b1; VGA_HS = 1'b0; BINARY_FLAG = 1'b0;
        tick();
        for (int y = 0; y < h; y++) begin
            for (int x = -2; x < w; x++) begin
                if (x < 0) begin
                    VGA_HS = 1'b0; BINARY_FLAG = 1'b0; H_CNT = 16'd0;
                end else begin
                    VGA_HS = 1'b1; H_CNT = 16'(x); V_CNT = 16'(y);
                    BINARY_FLAG = fg(mode, x, y);
                end
                if (x == 0 && hold_chk) check("hold");
                if (x == 0 && y == rst_line) begin
                    RST = 1'b1;
                    tick();
                    RST = 1'b0;
                    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    check("midrst");
                end else begin
                    tick();
                end
            end
        end
        VGA_HS = 1'b0; BINARY_FLAG = 1'b0; VGA_VS = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        tick(); tick(); tick();
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset");
        RST = 1'b0;
        tick();

        run_frame(1, 200, 100, 1'b0, -1);
        set_exp(12, 22, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("single");

        run_frame(2, 160, 90, 1'b0, -1);
        set_exp(30, 10, 90, 10, 150, 40, 50, 80, 15, 4, 0);
        check("four");

        run_frame(3, 110, 95, 1'b0, -1);
        set_exp(10, 10, 40, 10, 70, 30, 10, 60, 15, 4, 4);
        check("overflow");

        run_frame(4, 60, 10, 1'b0, -1);
        set_exp(41, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("gap2");

        run_frame(5, 60, 10, 1'b0, -1);
        set_exp(40, 5, 43, 5, 0, 0, 0, 0, 3, 2, 0);
        check("gap3");

        run_frame(0, 40, 10, 1'b0, -1);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("empty");

        run_frame(1, 40, 30, 1'b1, -1);
        set_exp(12, 22, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("repeat1");
        run_frame(1, 40, 30, 1'b1, -1);
        check("repeat2");

        run_frame(1, 40, 60, 1'b0, 50);
        run_frame(1, 40, 30, 1'b0, -1);
        set_exp(12, 22, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
